// File: rtl/road_scheduler_if.sv
// Control-unit <-> road scheduler bundle: selection requests in, served road out.
interface road_scheduler_if #(
  parameter int unsigned ROADS = 4
) ();
  localparam int unsigned ROAD_W = $clog2(ROADS);

  logic              start;
  logic              inc_road;
  logic [ROADS-1:0]  req;
  logic              emerg_valid;
  logic [ROAD_W-1:0] emerg_road;

  logic [ROAD_W-1:0] road;
  logic              road_valid;
  logic [ROADS-1:0]  grant;
  logic              emerg_active;
  logic [ROADS-1:0]  starved;

  modport master (
    output start, inc_road, req, emerg_valid, emerg_road,
    input  road, road_valid, grant, emerg_active, starved
  );

  modport slave (
    input  start, inc_road, req, emerg_valid, emerg_road,
    output road, road_valid, grant, emerg_active, starved
  );
endinterface

// File: rtl/road_scheduler.sv
// Demand-driven road sequencer: skips idle roads, forces starved ones in,
// and lets an emergency request preempt the choice.
module road_scheduler #(
  parameter int unsigned ROADS    = 4,
  parameter int unsigned WAIT_MAX = 3
) (
  input  logic            clk,
  input  logic            reset,
  road_scheduler_if.slave bus
);
  localparam int unsigned ROAD_W = $clog2(ROADS);
  localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_RR, S_EMERG} state_e;

  state_e            state_q, state_d;
  logic [ROAD_W-1:0] road_q, road_d;
  logic [ROAD_W-1:0] resume_q, resume_d;
  logic              road_valid_q, road_valid_d;
  logic              emerg_active_q, emerg_active_d;
  logic [ROADS-1:0]  grant_q, grant_d;
  logic [ROADS-1:0]  starved_q, starved_d;
  logic [WAIT_W-1:0] wait_q [ROADS];
  logic [WAIT_W-1:0] wait_d [ROADS];

  logic [ROAD_W-1:0] emerg_sel;
  logic [ROAD_W-1:0] base;
  logic [ROAD_W-1:0] idx;
  logic [ROAD_W-1:0] st_pick;
  logic [ROAD_W-1:0] rq_pick;
  logic [ROAD_W-1:0] pick;
  logic              st_found;
  logic              rq_found;
  logic              rr_sel;

  // Out-of-range emergency road indices fall back to road 0
  generate
    if (ROADS == (1 << ROAD_W)) begin : g_emerg_full
      assign emerg_sel = bus.emerg_road;
    end else begin : g_emerg_clip
      assign emerg_sel = (32'(bus.emerg_road) < ROADS) ? bus.emerg_road : '0;
    end
  endgenerate

  // Search origin: current road, or the slot before resume_ptr when leaving EMERG
  always_comb begin
    base = road_q;
    if (state_q == S_EMERG) begin
      base = ROAD_W'((32'(resume_q) + ROADS - 32'(1)) % ROADS);
    end
  end

  // First starved, else first requesting, else next road, in order base+1 .. base+ROADS
  always_comb begin
    st_found = 1'b0;
    rq_found = 1'b0;
    st_pick  = '0;
    rq_pick  = '0;
    idx      = '0;
    pick     = ROAD_W'((32'(base) + 32'(1)) % ROADS);
    for (int unsigned k = 1; k <= ROADS; k++) begin
      idx = ROAD_W'((32'(base) + k) % ROADS);
      if (!st_found && starved_q[idx]) begin
        st_found = 1'b1;
        st_pick  = idx;
      end
      if (!rq_found && bus.req[idx]) begin
        rq_found = 1'b1;
        rq_pick  = idx;
      end
    end
    if (st_found) begin
      pick = st_pick;
    end else if (rq_found) begin
      pick = rq_pick;
    end
  end

  // Next-state and selection
  always_comb begin
    state_d        = state_q;
    road_d         = road_q;
    resume_d       = resume_q;
    road_valid_d   = road_valid_q;
    emerg_active_d = emerg_active_q;
    rr_sel         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          road_valid_d = 1'b1;
          if (bus.emerg_valid) begin
            road_d         = emerg_sel;
            resume_d       = '0;
            emerg_active_d = 1'b1;
            state_d        = S_EMERG;
          end else begin
            road_d         = '0;
            emerg_active_d = 1'b0;
            state_d        = S_RR;
          end
        end
      end
      S_RR: begin
        if (bus.inc_road) begin
          if (bus.emerg_valid) begin
            road_d         = emerg_sel;
            resume_d       = ROAD_W'((32'(road_q) + 32'(1)) % ROADS);
            emerg_active_d = 1'b1;
            state_d        = S_EMERG;
          end else begin
            rr_sel = 1'b1;
          end
        end
      end
      S_EMERG: begin
        if (bus.inc_road) begin
          if (bus.emerg_valid) begin
            road_d = emerg_sel;
          end else begin
            rr_sel  = 1'b1;
            state_d = S_RR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rr_sel) begin
      road_d         = pick;
      emerg_active_d = 1'b0;
    end

    grant_d = road_valid_d ? (ROADS'(1) << road_d) : '0;
  end

  // Wait counters move only on normal-mode selections
  always_comb begin
    for (int unsigned i = 0; i < ROADS; i++) begin
      wait_d[i] = wait_q[i];
      if (rr_sel) begin
        if (ROAD_W'(i) == pick) begin
          wait_d[i] = '0;
        end else if (bus.req[i] && (wait_q[i] != WAIT_W'(WAIT_MAX))) begin
          wait_d[i] = wait_q[i] + WAIT_W'(1);
        end
      end
      starved_d[i] = (wait_d[i] == WAIT_W'(WAIT_MAX));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      road_q         <= '0;
      resume_q       <= '0;
      road_valid_q   <= 1'b0;
      emerg_active_q <= 1'b0;
      grant_q        <= '0;
      starved_q      <= '0;
      for (int unsigned i = 0; i < ROADS; i++) begin
        wait_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      road_q         <= road_d;
      resume_q       <= resume_d;
      road_valid_q   <= road_valid_d;
      emerg_active_q <= emerg_active_d;
      grant_q        <= grant_d;
      starved_q      <= starved_d;
      for (int unsigned i = 0; i < ROADS; i++) begin
        wait_q[i] <= wait_d[i];
      end
    end
  end

  assign bus.road         = road_q;
  assign bus.road_valid   = road_valid_q;
  assign bus.grant        = grant_q;
  assign bus.emerg_active = emerg_active_q;
  assign bus.starved      = starved_q;

endmodule
